mod_counter: RTL and testbench

Parametrised modulo up/down counter with enable, built-in prescaler, synchronous clear and load, and an optional saturate mode. It generalises the basic 4-bit free-running up counter: any width and any modulus, counting in either direction. Rate reduction is a clock-enable prescaler, not a derived clock. It sits in the timing/sequencing fabric, driving display digits, timeouts and cascaded counter chains. Chaining uses `tc` as the next stage's `en`.

---
 rtl/mod_counter.sv | 67 ++++++
 tb/tb_mod_counter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// mod_counter: modulo up/down counter with clock-enable prescaler, clear, load and optional saturation
module mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH:0] MAXW = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             step, at_lim;

    assign step   = en && (pre_q == PLAST);
    assign at_lim = up ? ({1'b0, q_q} == MAXW) : (q_q == '0);
    assign Q      = q_q;
    assign tc     = tc_q;

    // next state: clear beats load beats step; the prescaler only advances on enabled cycles
    always_comb begin
        pre_d = pre_q;
        q_d   = q_q;
        tc_d  = 1'b0;
        if (clr) begin
            pre_d = '0;
            q_d   = '0;
        end else if (load) begin
            pre_d = '0;
            q_d   = ({1'b0, load_val} > MAXW) ? QMAX : load_val;
        end else begin
            if (en)
                pre_d = step ? '0 : pre_q + 1'b1;
            if (step) begin
                tc_d = at_lim;
                q_d  = at_lim ? ((SATURATE != 0) ? q_q : (up ? '0 : QMAX))
                              : (up ? q_q + 1'b1 : q_q - 1'b1);
            end
        end
    end

    // state registers, cleared immediately by the active-low asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
            q_q   <= '0;
            tc_q  <= 1'b0;
        end else begin
            pre_q <= pre_d;
            q_q   <= q_d;
            tc_q  <= tc_d;
        end
    end
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed test of mod_counter against an arithmetic reference model
module tb_mod_counter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] q0, q1;
    logic [0:0] q2;
    logic tc0, tc1, tc2;

    int n_chk = 0;
    int n_fail = 0;

    int m_mod [3] = '{10, 10, 2};
    int m_pre [3] = '{3, 3, 1};
    int m_sat [3] = '{0, 1, 0};
    int mq [3] = '{0, 0, 0};
    int mp [3] = '{0, 0, 0};
    int mt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .Q(q0), .tc(tc0));

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .Q(q1), .tc(tc1));

    mod_counter #(.WIDTH(1), .MODULUS(2), .PRESCALE(1), .SATURATE(0)) u_m2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val[0:0]), .Q(q2), .tc(tc2));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: counts enabled cycles, steps every PRESCALE of them, wraps or saturates
    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                mq[i] = 0; mp[i] = 0; mt[i] = 0;
            end else if (clr) begin
                mq[i] = 0; mp[i] = 0; mt[i] = 0;
            end else if (load) begin
                int lv;
                lv = (i == 2) ? int'(load_val[0]) : int'(load_val);
                mq[i] = (lv > m_mod[i] - 1) ? m_mod[i] - 1 : lv;
                mp[i] = 0; mt[i] = 0;
            end else begin
                bit stp;
                stp = en && (mp[i] == m_pre[i] - 1);
                mt[i] = 0;
                if (en) mp[i] = stp ? 0 : mp[i] + 1;
                if (stp) begin
                    if (up) begin
                        if (mq[i] == m_mod[i] - 1) begin
                            mt[i] = 1;
                            if (m_sat[i] == 0) mq[i] = 0;
                        end else mq[i] = mq[i] + 1;
                    end else begin
                        if (mq[i] == 0) begin
                            mt[i] = 1;
                            if (m_sat[i] == 0) mq[i] = m_mod[i] - 1;
                        end else mq[i] = mq[i] - 1;
                    end
                end
            end
        end
    end

    // every-cycle comparison of all three counters against the model
    always @(negedge clk) begin
        chk("wrap_q", int'(q0), mq[0]);
        chk("wrap_tc", int'(tc0), mt[0]);
        chk("sat_q", int'(q1), mq[1]);
        chk("sat_tc", int'(tc1), mt[1]);
        chk("m2_q", int'(q2), mq[2]);
        chk("m2_tc", int'(tc2), mt[2]);
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #12 reset = 1'b1;
        @(negedge clk);
        chk("rst_q", int'(q0), 0);
        chk("rst_tc", int'(tc0), 0);
        en = 1'b1; up = 1'b1;
        edges(3);
        chk("up_first_step", int'(q0), 1);
        edges(27);
        chk("wrap_to0", int'(q0), 0);
        chk("wrap_tc_pulse", int'(tc0), 1);
        chk("sat_at9", int'(q1), 9);
        chk("sat_tc_pulse", int'(tc1), 1);
        edges(1);
        chk("wrap_tc_end", int'(tc0), 0);
        chk("sat_tc_end", int'(tc1), 0);
        edges(2);
        chk("sat_hold", int'(q1), 9);
        chk("sat_tc_again", int'(tc1), 1);
        load = 1'b1; load_val = 4'd7;
        edges(1);
        chk("load7", int'(q0), 7);
        load = 1'b0;
        edges(2);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_q", int'(q0), 0);
        chk("async_rst_tc", int'(tc0), 0);
        chk("async_rst_sat_q", int'(q1), 0);
        @(negedge clk);
        reset = 1'b1;
        edges(2);
        chk("post_rst_wait", int'(q0), 0);
        edges(1);
        chk("post_rst_step", int'(q0), 1);
        clr = 1'b1;
        edges(1);
        chk("clr", int'(q0), 0);
        clr = 1'b0; up = 1'b0;
        edges(3);
        chk("down_wrap", int'(q0), 9);
        chk("down_wrap_tc", int'(tc0), 1);
        chk("sat_down_hold", int'(q1), 0);
        chk("sat_down_tc", int'(tc1), 1);
        edges(3);
        chk("down_8", int'(q0), 8);
        chk("down_8_tc", int'(tc0), 0);
        up = 1'b1;
        edges(3);
        chk("dir_9", int'(q0), 9);
        chk("dir_9_tc", int'(tc0), 0);
        load = 1'b1; load_val = 4'd13;
        edges(1);
        chk("load_clamp", int'(q0), 9);
        chk("load_clamp_tc", int'(tc0), 0);
        clr = 1'b1; load_val = 4'd5;
        edges(1);
        chk("clr_beats_load", int'(q0), 0);
        clr = 1'b0; load = 1'b0;
        edges(2);
        chk("clr_pre_restart", int'(q0), 0);
        edges(1);
        chk("clr_next_step", int'(q0), 1);
        load = 1'b1; load_val = 4'd9;
        edges(1);
        load = 1'b0;
        edges(2);
        load = 1'b1; load_val = 4'd4;
        edges(1);
        chk("load_beats_step", int'(q0), 4);
        chk("load_step_tc", int'(tc0), 0);
        load = 1'b0; clr = 1'b1;
        edges(1);
        clr = 1'b0;
        en = 1'b1; edges(1);
        en = 1'b0; edges(1);
        en = 1'b1; edges(1);
        en = 1'b0; edges(1);
        chk("gate_hold", int'(q0), 0);
        en = 1'b1; edges(1);
        chk("gate_step", int'(q0), 1);
        en = 1'b0;
        edges(4);
        chk("gate_idle", int'(q0), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
